// File: rtl/protected_read_input_buffer.sv
// protected_read_input_buffer
// Request-side FWFT queue for the protected read unit. Requesters push a
// (process token, object id) pair; the permission-read engine sees the oldest
// entry on the outputs without asking and pops it with read_enable.
// Optional feature: define PROTECTED_READ_INPUT_OVERFLOW_EN to add the sticky
// overflow_out flag that records any push dropped because the queue was full.
module protected_read_input_buffer #(
    parameter int process_token_register_width = 160,
    parameter int object_id_width              = 32,
    parameter int depth                        = 4,
    parameter int ptr_width                    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    write_enable,
    input  logic [process_token_register_width-1:0] process_token_in,
    input  logic [object_id_width-1:0]              object_id_in,
    input  logic                                    read_enable,
    output logic [process_token_register_width-1:0] process_token_out,
    output logic [object_id_width-1:0]              object_id_out,
    output logic                                    status_of_input_data_out,
    output logic                                    full,
    output logic [ptr_width:0]                      count
`ifdef PROTECTED_READ_INPUT_OVERFLOW_EN
    ,
    output logic                                    overflow_out
`endif
);

    localparam logic [ptr_width:0] depth_cnt = (ptr_width + 1)'(depth);

    // Entry storage; only ever read through the count-gated output mux.
    logic [process_token_register_width-1:0] token_mem [depth];
    logic [object_id_width-1:0]              id_mem    [depth];

    logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_width:0]   count_q,  count_d;
    logic                 full_q,   full_d;
    logic                 status_q, status_d;
    logic                 push;
    logic                 pop;

    // Accept/pop decisions and next-state for pointers, count and status.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave a value unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A full queue still accepts a push when the head leaves the same cycle.
        push = write_enable && (!full_q || read_enable);
        // An empty queue ignores the pop even if a push lands this cycle.
        pop  = read_enable && (count_q != '0);

        if (push) wr_ptr_d = wr_ptr_q + ptr_width'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_width'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + (ptr_width + 1)'(1);
            2'b01:   count_d = count_q - (ptr_width + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d   = (count_d == depth_cnt);
        status_d = (count_d != '0);
    end

    // Control state; cleared asynchronously so a reset discards the queue at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            status_q <= status_d;
        end
    end

    // Entry write on an accepted push.
    // NOTE: the storage array has no reset; stale contents are never visible
    // because the outputs are forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            token_mem[wr_ptr_q] <= process_token_in;
            id_mem[wr_ptr_q]    <= object_id_in;
        end
    end

    // FWFT head: combinational from the read pointer, zero when nothing is queued.
    assign process_token_out        = (count_q != '0) ? token_mem[rd_ptr_q] : '0;
    assign object_id_out            = (count_q != '0) ? id_mem[rd_ptr_q]    : '0;
    assign status_of_input_data_out = status_q;
    assign full                     = full_q;
    assign count                    = count_q;

`ifdef PROTECTED_READ_INPUT_OVERFLOW_EN
    logic overflow_q;
    logic overflow_d;

    // Sticky record of a push dropped against a full queue with no pop.
    always_comb begin
        overflow_d = overflow_q | (write_enable && full_q && !read_enable);
    end

    // Overflow flag clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow_out = overflow_q;
`endif

endmodule

// File: tb/tb_protected_read_input_buffer.sv
// Bench for protected_read_input_buffer: directed vector table, hand-written
// asynchronous-reset sequence, then randomized traffic against a queue model.
module tb_protected_read_input_buffer;

    localparam int tw = 160;
    localparam int iw = 32;
    localparam int dp = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            write_enable;
    logic [tw-1:0]   process_token_in;
    logic [iw-1:0]   object_id_in;
    logic            read_enable;
    logic [tw-1:0]   process_token_out;
    logic [iw-1:0]   object_id_out;
    logic            status_of_input_data_out;
    logic            full;
    logic [2:0]      count;
    logic            ovf;

    protected_read_input_buffer #(
        .process_token_register_width(tw),
        .object_id_width(iw),
        .depth(dp),
        .ptr_width(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_enable(write_enable),
        .process_token_in(process_token_in),
        .object_id_in(object_id_in),
        .read_enable(read_enable),
        .process_token_out(process_token_out),
        .object_id_out(object_id_out),
        .status_of_input_data_out(status_of_input_data_out),
        .full(full),
        .count(count)
`ifdef PROTECTED_READ_INPUT_OVERFLOW_EN
        ,
        .overflow_out(ovf)
`endif
    );

`ifndef PROTECTED_READ_INPUT_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [tw-1:0] act, input logic [tw-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed-test token derived from the object id so token and id are checked together.
    function automatic logic [tw-1:0] tok_of(input logic [iw-1:0] id);
        return {5{32'hA5A5_A5A5}} ^ {128'b0, id};
    endfunction

    typedef struct {
        logic          we;
        logic [iw-1:0] id;
        logic          re;
        int            exp_cnt;
        logic [iw-1:0] exp_id;
        logic          exp_ovf;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [iw-1:0] id, input logic re,
                                input int cnt, input logic [iw-1:0] hid, input logic o);
        vec_t v;
        v.we = we; v.id = id; v.re = re;
        v.exp_cnt = cnt; v.exp_id = hid; v.exp_ovf = o;
        return v;
    endfunction

    // Compare all outputs against an expected queue state.
    task automatic check_state(input string tag, input int cnt, input logic [tw-1:0] htok,
                               input logic [iw-1:0] hid, input logic o);
        check({tag, ".count"},  tw'(count), tw'(cnt));
        check({tag, ".full"},   tw'(full), tw'(cnt == dp));
        check({tag, ".status"}, tw'(status_of_input_data_out), tw'(cnt != 0));
        check({tag, ".token"},  process_token_out, (cnt != 0) ? htok : '0);
        check({tag, ".id"},     tw'(object_id_out), (cnt != 0) ? tw'(hid) : '0);
`ifdef PROTECTED_READ_INPUT_OVERFLOW_EN
        check({tag, ".ovf"},    tw'(ovf), tw'(o));
`endif
    endtask

    task automatic step(input logic we, input logic [tw-1:0] tok, input logic [iw-1:0] id, input logic re);
        write_enable     = we;
        process_token_in = tok;
        object_id_in     = id;
        read_enable      = re;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    typedef struct {
        logic [tw-1:0] tok;
        logic [iw-1:0] id;
    } entry_t;

    vec_t   vecs[16];
    entry_t q[$];

    initial begin
        vecs[0]  = mk(0, 32'h00, 0, 0, 32'h00, 0); // idle: outputs 0 before any push
        vecs[1]  = mk(1, 32'h10, 0, 1, 32'h10, 0); // first push visible next cycle
        vecs[2]  = mk(0, 32'h00, 1, 0, 32'h00, 0);
        vecs[3]  = mk(1, 32'h01, 0, 1, 32'h01, 0);
        vecs[4]  = mk(1, 32'h02, 0, 2, 32'h01, 0);
        vecs[5]  = mk(1, 32'h03, 0, 3, 32'h01, 0);
        vecs[6]  = mk(1, 32'h04, 0, 4, 32'h01, 0); // full
        vecs[7]  = mk(1, 32'h05, 0, 4, 32'h01, 1); // dropped push
        vecs[8]  = mk(1, 32'h05, 1, 4, 32'h02, 1); // push+pop when full
        vecs[9]  = mk(0, 32'h00, 1, 3, 32'h03, 1);
        vecs[10] = mk(0, 32'h00, 1, 2, 32'h04, 1);
        vecs[11] = mk(0, 32'h00, 1, 1, 32'h05, 1); // wrapped entry last out
        vecs[12] = mk(0, 32'h00, 1, 0, 32'h00, 1);
        vecs[13] = mk(1, 32'h07, 1, 1, 32'h07, 1); // empty push+pop: push wins
        vecs[14] = mk(0, 32'h00, 1, 0, 32'h00, 1);
        vecs[15] = mk(0, 32'h00, 1, 0, 32'h00, 1); // read while empty ignored

        rst_n            = 1'b0;
        write_enable     = 1'b0;
        read_enable      = 1'b0;
        process_token_in = '0;
        object_id_in     = '0;
        #12;
        check_state("reset", 0, '0, '0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].we, tok_of(vecs[i].id), vecs[i].id, vecs[i].re);
            check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, tok_of(vecs[i].exp_id),
                        vecs[i].exp_id, vecs[i].exp_ovf);
        end

        // Asynchronous reset between edges with three entries queued.
        step(1, tok_of(32'h21), 32'h21, 0);
        step(1, tok_of(32'h22), 32'h22, 0);
        step(1, tok_of(32'h23), 32'h23, 0);
        check_state("pre_arst", 3, tok_of(32'h21), 32'h21, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("arst", 0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, tok_of(32'h99), 32'h99, 0);
        check_state("post_arst", 1, tok_of(32'h99), 32'h99, 1'b0);
        step(0, '0, '0, 1);
        check_state("post_arst_pop", 0, '0, '0, 1'b0);

        // Randomized traffic against a queue model.
        begin
            logic sticky = 1'b0;
            for (int c = 0; c < 400; c++) begin
                entry_t e;
                logic   we, re;
                bit     was_full;
                we = ($urandom_range(99) < 60);
                re = ($urandom_range(99) < 45);
                e.tok = {$urandom, $urandom, $urandom, $urandom, $urandom};
                e.id  = $urandom;
                was_full = (q.size() == dp);
                if (we && was_full && !re) sticky = 1'b1;
                if (re && q.size() != 0) void'(q.pop_front());
                if (we && (!was_full || re)) q.push_back(e);
                step(we, e.tok, e.id, re);
                if (q.size() != 0)
                    check_state($sformatf("rnd%0d", c), q.size(), q[0].tok, q[0].id, sticky);
                else
                    check_state($sformatf("rnd%0d", c), 0, '0, '0, sticky);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/protected_read_input_buffer.md
Name: protected_read_input_buffer

Overview:
- Request-side buffer for the protected read unit; the counterpart of the response-side output buffer.
- Accepts read requests from the requesting process: a process token plus the object identifier to read.
- Queues requests in a small FIFO and presents the oldest one to the permission-read engine.
- The engine consumes the head with a read strobe; requester-facing status reports full and occupancy.

Parameters:
- process_token_register_width, 160, width of the process token carried with each request
- object_id_width, 32, width of the object identifier being read
- depth, 4, number of request entries; power of two, minimum 2
- ptr_width, 2, log2(depth); the count field is ptr_width+1 bits

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- write_enable  input  1  requester strobe; push one request this cycle
- process_token_in  input  process_token_register_width  token of the pushing request
- object_id_in  input  object_id_width  object identifier of the pushing request
- read_enable  input  1  engine strobe; pop the head entry this cycle
- process_token_out  output  process_token_register_width  token of the head entry
- object_id_out  output  object_id_width  object identifier of the head entry
- status_of_input_data_out  output  1  1 when at least one request is queued
- full  output  1  1 when count == depth
- count  output  ptr_width+1  number of queued requests, 0..depth

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rst_n.
- Reset: write pointer, read pointer and count go to 0; full=0; status_of_input_data_out=0; data outputs read 0. Storage array is not reset.
- Reset asserted mid-operation: all queued requests are discarded immediately, without waiting for a clock edge.
- FWFT organisation: a pushed entry is visible on the outputs the cycle after its push edge. The head appears on the outputs with no read request needed.
- Data outputs are combinational from storage[rd_ptr], gated to all-zero when count==0.
- Push accepted: write_enable && (!full || read_enable).
  - Entry is written to storage[wr_ptr].
  - wr_ptr increments modulo depth, wrapping naturally at ptr_width bits.
- Pop accepted: read_enable && count!=0.
  - rd_ptr increments modulo depth.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged; applies when full and when count is between 1 and depth-1.
- Empty with write_enable and read_enable together: push accepted, pop ignored; count becomes 1.
- Write while full without read_enable: request dropped; no pointer or count change.
- Read while empty: ignored; no pointer or count change.
- Status outputs:
  - full and status_of_input_data_out are registered, updated on the same edge as count.
  - status_of_input_data_out == (count!=0).
- Latency: push edge to status_of_input_data_out=1 is one clock. Pop edge to next head on outputs is zero additional cycles.

Optional Feature:
- Macro: PROTECTED_READ_INPUT_OVERFLOW_EN.
- Defined:
  - Extra output port overflow_out (1 bit) is added.
  - overflow_out is a sticky flag, set on the edge of any dropped push (write_enable && full && !read_enable).
  - Cleared only by rst_n.
- Undefined:
  - The port and its flop are absent.
  - Dropped pushes are silent.

Test Plan:
- Reset, then push token=0xA5.., object_id=0x00000010 -> next cycle count=1, status=1, outputs show 0xA5../0x10; before the push, outputs are 0.
- Push 4 requests with ids 1,2,3,4 -> full=1, count=4; pop four times -> outputs step 1,2,3,4, then count=0, status=0, outputs 0.
- Full, push id=5 without read_enable -> count stays 4, head stays 1. With the macro defined, overflow_out=1 and stays 1 until reset.
- Full, push id=5 with read_enable -> count=4, head becomes 2; after draining, id 5 is the last entry out (wrap-around check).
- Empty, write_enable and read_enable in the same cycle with id=7 -> count=1, head=7; read_enable alone when empty -> no change.
- Queue 3 entries, drop rst_n low between clock edges -> count, status and full go to 0 immediately; after release, the first push appears at the head correctly.
